// File: rtl/sram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the SRAM controller.
// slave = arbiter view, master = requesters plus SRAM controller view.
interface sram_arbiter_if #(
    parameter int ADDR_W  = 18,
    parameter int WDATA_W = 32,
    parameter int RDATA_W = 64
) ();
    logic [1:0]         req;
    logic [1:0]         we;
    logic [ADDR_W-1:0]  addr0;
    logic [ADDR_W-1:0]  addr1;
    logic [WDATA_W-1:0] wdata0;
    logic [WDATA_W-1:0] wdata1;
    logic [1:0]         done;
    logic [1:0]         err;
    logic [1:0]         freeze;
    logic [RDATA_W-1:0] rdata;
    logic               sram_r_en;
    logic               sram_w_en;
    logic [ADDR_W-1:0]  sram_addr;
    logic [WDATA_W-1:0] sram_wdata;
    logic [RDATA_W-1:0] sram_rdata;
    logic               sram_done;

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, sram_rdata, sram_done,
        output done, err, freeze, rdata, sram_r_en, sram_w_en, sram_addr, sram_wdata
    );

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, sram_rdata, sram_done,
        input  done, err, freeze, rdata, sram_r_en, sram_w_en, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single SRAM controller port (IDLE -> BUSY -> RESP).
// Optional busy watchdog enabled by defining SRAM_ARB_TIMEOUT_EN.
module sram_arbiter #(
    parameter int ADDR_W      = 18,
    parameter int WDATA_W     = 32,
    parameter int RDATA_W     = 64,
    parameter int FIXED_PRIO  = 0,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]         state_r;
    logic               id_r;
    logic               we_r;
    logic               last_gnt_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [WDATA_W-1:0] wdata_r;
    logic [RDATA_W-1:0] rdata_r;
    logic [1:0]         done_r;
    logic               r_en_r;
    logic               w_en_r;
    logic               win_s;

    function automatic logic [1:0] port_onehot(input logic id);
        port_onehot = {id, ~id};
    endfunction

    // Winner selection: ties go to port 0 under fixed priority, else to the port not granted last.
    always_comb begin
        win_s = 1'b0;
        if (bus.req == 2'b11) begin
            if (FIXED_PRIO != 0) begin
                win_s = 1'b0;
            end else begin
                win_s = ~last_gnt_r;
            end
        end else if (bus.req == 2'b10) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       err_r;
    assign bus.err = err_r;
`else
    assign bus.err = 2'b00;
`endif

    // Transaction FSM: latch the winner's command, hold the enable, then pulse done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            id_r       <= 1'b0;
            we_r       <= 1'b0;
            last_gnt_r <= 1'b1;
            addr_r     <= {ADDR_W{1'b0}};
            wdata_r    <= {WDATA_W{1'b0}};
            rdata_r    <= {RDATA_W{1'b0}};
            done_r     <= 2'b00;
            r_en_r     <= 1'b0;
            w_en_r     <= 1'b0;
`ifdef SRAM_ARB_TIMEOUT_EN
            cnt_r      <= {CNT_W{1'b0}};
            err_r      <= 2'b00;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|bus.req) begin
                        id_r       <= win_s;
                        we_r       <= bus.we[win_s];
                        last_gnt_r <= win_s;
                        addr_r     <= win_s ? bus.addr1 : bus.addr0;
                        wdata_r    <= win_s ? bus.wdata1 : bus.wdata0;
                        r_en_r     <= ~bus.we[win_s];
                        w_en_r     <= bus.we[win_s];
                        state_r    <= ST_BUSY;
`ifdef SRAM_ARB_TIMEOUT_EN
                        cnt_r      <= {CNT_W{1'b0}};
`endif
                    end
                end
                ST_BUSY: begin
                    if (bus.sram_done) begin
                        if (!we_r) begin
                            rdata_r <= bus.sram_rdata;
                        end
                        r_en_r  <= 1'b0;
                        w_en_r  <= 1'b0;
                        done_r  <= port_onehot(id_r);
                        state_r <= ST_RESP;
`ifdef SRAM_ARB_TIMEOUT_EN
                    end else if (cnt_r == CNT_W'(TIMEOUT_CYC - 1)) begin
                        // Watchdog expiry: close the transaction with an error and a zero line.
                        rdata_r <= {RDATA_W{1'b0}};
                        r_en_r  <= 1'b0;
                        w_en_r  <= 1'b0;
                        done_r  <= port_onehot(id_r);
                        err_r   <= port_onehot(id_r);
                        state_r <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
`endif
                    end
                end
                ST_RESP: begin
                    done_r  <= 2'b00;
                    state_r <= ST_IDLE;
`ifdef SRAM_ARB_TIMEOUT_EN
                    err_r   <= 2'b00;
`endif
                end
                default: begin
                    done_r  <= 2'b00;
                    r_en_r  <= 1'b0;
                    w_en_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.done       = done_r;
    assign bus.freeze     = bus.req & ~done_r;
    assign bus.rdata      = rdata_r;
    assign bus.sram_r_en  = r_en_r;
    assign bus.sram_w_en  = w_en_r;
    assign bus.sram_addr  = addr_r;
    assign bus.sram_wdata = wdata_r;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: round-robin instance (dut0) and fixed-priority instance (dut1).
module tb_sram_arbiter;
    logic clk;
    logic rst;
    int   chk_cnt;
    int   pass_cnt;
    int   both_hi;

    sram_arbiter_if #(.ADDR_W(18), .WDATA_W(32), .RDATA_W(64)) bus0 ();
    sram_arbiter_if #(.ADDR_W(18), .WDATA_W(32), .RDATA_W(64)) bus1 ();

    sram_arbiter #(.ADDR_W(18), .WDATA_W(32), .RDATA_W(64), .FIXED_PRIO(0), .TIMEOUT_CYC(8))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    sram_arbiter #(.ADDR_W(18), .WDATA_W(32), .RDATA_W(64), .FIXED_PRIO(1), .TIMEOUT_CYC(255))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ((bus0.sram_r_en && bus0.sram_w_en) || (bus1.sram_r_en && bus1.sram_w_en)) begin
            both_hi++;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        chk_cnt = 0; pass_cnt = 0; both_hi = 0;
        rst = 1'b0;
        bus0.req = 2'b00; bus0.we = 2'b00; bus0.addr0 = 18'h0; bus0.addr1 = 18'h0;
        bus0.wdata0 = 32'h0; bus0.wdata1 = 32'h0; bus0.sram_rdata = 64'h0; bus0.sram_done = 1'b0;
        bus1.req = 2'b00; bus1.we = 2'b00; bus1.addr0 = 18'h0; bus1.addr1 = 18'h0;
        bus1.wdata0 = 32'h0; bus1.wdata1 = 32'h0; bus1.sram_rdata = 64'h0; bus1.sram_done = 1'b0;
        tick(); tick();

        check_val("rst_r_en",   64'(bus0.sram_r_en),  64'h0);
        check_val("rst_w_en",   64'(bus0.sram_w_en),  64'h0);
        check_val("rst_done",   64'(bus0.done),       64'h0);
        check_val("rst_err",    64'(bus0.err),        64'h0);
        check_val("rst_rdata",  bus0.rdata,           64'h0);
        check_val("rst_addr",   64'(bus0.sram_addr),  64'h0);
        check_val("rst_wdata",  64'(bus0.sram_wdata), 64'h0);
        rst = 1'b1;
        tick();

        // Single read, port 0, sram_done after 4 enable cycles
        bus0.req = 2'b01; bus0.we = 2'b00; bus0.addr0 = 18'h00010;
        tick();
        check_val("rd_r_en_c1",  64'(bus0.sram_r_en), 64'h1);
        check_val("rd_w_en_c1",  64'(bus0.sram_w_en), 64'h0);
        check_val("rd_addr",     64'(bus0.sram_addr), 64'h10);
        check_val("rd_freeze",   64'(bus0.freeze),    64'h1);
        tick();
        check_val("rd_r_en_c2",  64'(bus0.sram_r_en), 64'h1);
        tick();
        check_val("rd_r_en_c3",  64'(bus0.sram_r_en), 64'h1);
        tick();
        check_val("rd_r_en_c4",  64'(bus0.sram_r_en), 64'h1);
        check_val("rd_done_c4",  64'(bus0.done),      64'h0);
        bus0.sram_done = 1'b1; bus0.sram_rdata = 64'h1122334455667788;
        tick();
        bus0.sram_done = 1'b0;
        check_val("rd_done",     64'(bus0.done),      64'h1);
        check_val("rd_rdata",    bus0.rdata,          64'h1122334455667788);
        check_val("rd_r_en_off", 64'(bus0.sram_r_en), 64'h0);
        check_val("rd_w_en_off", 64'(bus0.sram_w_en), 64'h0);
        check_val("rd_freeze_f", 64'(bus0.freeze),    64'h0);
        bus0.req = 2'b00;
        tick();
        check_val("rd_done_1cy", 64'(bus0.done),      64'h0);

        // Single write, port 1; later addr/wdata changes must be ignored
        bus0.req = 2'b10; bus0.we = 2'b10; bus0.addr1 = 18'h3FFF8; bus0.wdata1 = 32'hDEADBEEF;
        tick();
        check_val("wr_w_en",   64'(bus0.sram_w_en),  64'h1);
        check_val("wr_r_en",   64'(bus0.sram_r_en),  64'h0);
        check_val("wr_addr",   64'(bus0.sram_addr),  64'h3FFF8);
        check_val("wr_wdata",  64'(bus0.sram_wdata), 64'hDEADBEEF);
        bus0.addr1 = 18'h00123; bus0.wdata1 = 32'h0;
        tick();
        check_val("wr_addr_hold",  64'(bus0.sram_addr),  64'h3FFF8);
        check_val("wr_wdata_hold", 64'(bus0.sram_wdata), 64'hDEADBEEF);
        check_val("wr_w_en_hold",  64'(bus0.sram_w_en),  64'h1);
        bus0.sram_done = 1'b1; bus0.sram_rdata = 64'hFFFF0000FFFF0000;
        tick();
        bus0.sram_done = 1'b0;
        check_val("wr_done",   64'(bus0.done),      64'h2);
        check_val("wr_rdata",  bus0.rdata,          64'h1122334455667788);
        check_val("wr_w_off",  64'(bus0.sram_w_en), 64'h0);
        bus0.req = 2'b00; bus0.we = 2'b00;
        tick();

        // Round-robin with both ports held: 0,1,0,1 with an idle cycle in between
        bus0.req = 2'b11; bus0.addr0 = 18'h00100; bus0.addr1 = 18'h00200;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("rr_addr", 64'(bus0.sram_addr), (i % 2 == 0) ? 64'h100 : 64'h200);
            check_val("rr_r_en", 64'(bus0.sram_r_en), 64'h1);
            bus0.sram_done = 1'b1; bus0.sram_rdata = 64'(i + 16);
            tick();
            bus0.sram_done = 1'b0;
            check_val("rr_done",   64'(bus0.done),   (i % 2 == 0) ? 64'h1 : 64'h2);
            check_val("rr_rdata",  bus0.rdata,       64'(i + 16));
            check_val("rr_freeze", 64'(bus0.freeze), (i % 2 == 0) ? 64'h2 : 64'h1);
            tick();
            check_val("rr_idle_en",   64'(bus0.sram_r_en), 64'h0);
            check_val("rr_idle_done", 64'(bus0.done),      64'h0);
        end
        bus0.req = 2'b00;
        tick();
        tick();

        // Fixed priority: port 0 wins every transaction, port 1 stays frozen
        bus1.req = 2'b11; bus1.addr0 = 18'h00AAA; bus1.addr1 = 18'h00BBB;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("fp_addr",    64'(bus1.sram_addr), 64'hAAA);
            check_val("fp_freeze1", 64'(bus1.freeze[1]), 64'h1);
            bus1.sram_done = 1'b1;
            tick();
            bus1.sram_done = 1'b0;
            check_val("fp_done",    64'(bus1.done),      64'h1);
            check_val("fp_freeze",  64'(bus1.freeze),    64'h2);
            tick();
        end
        bus1.req = 2'b00;
        tick();

        // Reset while a port 1 read is in BUSY
        bus0.req = 2'b10; bus0.we = 2'b00; bus0.addr1 = 18'h00055;
        tick();
        check_val("mr_r_en_pre", 64'(bus0.sram_r_en), 64'h1);
        #2;
        rst = 1'b0;
        #1;
        check_val("mr_r_en_async", 64'(bus0.sram_r_en), 64'h0);
        check_val("mr_addr_async", 64'(bus0.sram_addr), 64'h0);
        check_val("mr_rdata_async", bus0.rdata,         64'h0);
        tick(); tick();
        check_val("mr_done_rst", 64'(bus0.done), 64'h0);
        rst = 1'b1;
        bus0.req = 2'b11; bus0.addr0 = 18'h00077;
        tick();
        check_val("mr_first_tie", 64'(bus0.sram_addr), 64'h77);
        bus0.sram_done = 1'b1; bus0.sram_rdata = 64'hA5A5A5A5A5A5A5A5;
        tick();
        bus0.sram_done = 1'b0;
        check_val("mr_done", 64'(bus0.done), 64'h1);
        bus0.req = 2'b00;
        tick();

`ifdef SRAM_ARB_TIMEOUT_EN
        // Watchdog: no sram_done, RESP after 8 BUSY cycles with err and zero line
        bus0.req = 2'b01; bus0.we = 2'b00; bus0.addr0 = 18'h00010;
        tick();
        for (int k = 0; k < 7; k++) begin
            tick();
        end
        check_val("to_busy_c8", 64'(bus0.sram_r_en), 64'h1);
        check_val("to_done_c8", 64'(bus0.done),      64'h0);
        tick();
        check_val("to_done",  64'(bus0.done),      64'h1);
        check_val("to_err",   64'(bus0.err),       64'h1);
        check_val("to_rdata", bus0.rdata,          64'h0);
        check_val("to_r_en",  64'(bus0.sram_r_en), 64'h0);
        bus0.req = 2'b00;
        tick();
        bus0.sram_done = 1'b1;
        tick();
        bus0.sram_done = 1'b0;
        check_val("to_late_done", 64'(bus0.done), 64'h0);
        check_val("to_late_err",  64'(bus0.err),  64'h0);
        tick();
        check_val("to_late_en",   64'(bus0.sram_r_en), 64'h0);
`else
        // No watchdog: BUSY waits indefinitely and err stays low
        bus0.req = 2'b01; bus0.we = 2'b00; bus0.addr0 = 18'h00010;
        tick();
        for (int k = 0; k < 20; k++) begin
            tick();
        end
        check_val("nt_busy", 64'(bus0.sram_r_en), 64'h1);
        check_val("nt_done", 64'(bus0.done),      64'h0);
        bus0.sram_done = 1'b1; bus0.sram_rdata = 64'h0123456789ABCDEF;
        tick();
        bus0.sram_done = 1'b0;
        check_val("nt_done_end", 64'(bus0.done), 64'h1);
        check_val("nt_err",      64'(bus0.err),  64'h0);
        check_val("nt_rdata",    bus0.rdata,     64'h0123456789ABCDEF);
        bus0.req = 2'b00;
        tick();
`endif

        // Spurious sram_done while IDLE must not produce done
        bus0.sram_done = 1'b1;
        tick();
        bus0.sram_done = 1'b0;
        check_val("spur_done", 64'(bus0.done),      64'h0);
        check_val("spur_en",   64'(bus0.sram_r_en), 64'h0);

        check_val("mutex", 64'(both_hi), 64'h0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
